// File: rtl/rk2_tx.sv
// rk2_tx: sends a 16-bit word as a three-byte frame (header, high, low), waits for ack/err,
// and re-sends after a cs-high gap on timeout or error until the retry budget runs out.
module rk2_tx #(
    parameter logic [7:0] HEADER      = 8'hCA,
    parameter int         ACK_TIMEOUT = 8,
    parameter int         MAX_RETRY   = 2,
    parameter int         GAP         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] d_in,
    input  logic        ack,
    input  logic        err,
    output logic        cs,
    output logic [7:0]  d_out,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [1:0]  retries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_WAIT,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_shadow;
    logic [7:0]  r_cnt;
    logic [1:0]  r_retries;
    logic        r_cs;
    logic [7:0]  r_d_out;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;

    state_t      w_state_next;
    logic [15:0] w_shadow_next;
    logic [7:0]  w_cnt_next;
    logic [1:0]  w_retries_next;
    logic        w_cs_next;
    logic [7:0]  w_d_out_next;
    logic        w_done_next;
    logic        w_fail_next;
    logic        w_attempt_failed;

    // err wins over ack; a silent line fails only once the last allowed WAIT cycle passes.
    assign w_attempt_failed = err || (!ack && (r_cnt == 8'(ACK_TIMEOUT)));

    always_comb begin
        w_state_next   = r_state;
        w_shadow_next  = r_shadow;
        w_cnt_next     = r_cnt;
        w_retries_next = r_retries;
        w_done_next    = 1'b0;
        w_fail_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shadow_next  = d_in;
                    w_retries_next = 2'd0;
                    w_state_next   = S_HDR;
                end
            end
            S_HDR: w_state_next = S_HI;
            S_HI:  w_state_next = S_LO;
            S_LO: begin
                w_cnt_next   = 8'd1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_attempt_failed) begin
                    if (r_retries < 2'(MAX_RETRY)) begin
                        w_retries_next = r_retries + 2'd1;
                        w_cnt_next     = 8'd1;
                        w_state_next   = (GAP == 0) ? S_HDR : S_GAP;
                    end else begin
                        w_fail_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else if (ack) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (r_cnt >= 8'(GAP)) begin
                    w_state_next = S_HDR;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_cs_next    = 1'b1;
        w_d_out_next = 8'h00;
        case (w_state_next)
            S_HDR: begin
                w_cs_next    = 1'b0;
                w_d_out_next = HEADER;
            end
            S_HI: begin
                w_cs_next    = 1'b0;
                w_d_out_next = w_shadow_next[15:8];
            end
            S_LO: begin
                w_cs_next    = 1'b0;
                w_d_out_next = w_shadow_next[7:0];
            end
            default: begin
                w_cs_next    = 1'b1;
                w_d_out_next = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= 16'h0000;
            r_cnt     <= 8'd0;
            r_retries <= 2'd0;
            r_cs      <= 1'b1;
            r_d_out   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shadow  <= w_shadow_next;
            r_cnt     <= w_cnt_next;
            r_retries <= w_retries_next;
            r_cs      <= w_cs_next;
            r_d_out   <= w_d_out_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= w_done_next;
            r_fail    <= w_fail_next;
        end
    end

    assign cs      = r_cs;
    assign d_out   = r_d_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fail    = r_fail;
    assign retries = r_retries;

endmodule

// File: tb/tb_rk2_tx.sv
// Directed bench for rk2_tx: nominal send, retry, exhaustion, ignored inputs,
// simultaneous ack/err and mid-frame reset, each against hand-derived values.
module tb_rk2_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] d_in = 16'h0000;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        cs;
    logic [7:0]  d_out;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  retries;

    int n_cmp = 0;
    int n_err = 0;

    rk2_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .d_in    (d_in),
        .ack     (ack),
        .err     (err),
        .cs      (cs),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done),
        .fail    (fail),
        .retries (retries)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] exp_retries);
        chk({tag, ".cs"}, 16'(cs), 16'h1);
        chk({tag, ".d_out"}, 16'(d_out), 16'h00);
        chk({tag, ".busy"}, 16'(busy), 16'h0);
        chk({tag, ".retries"}, 16'(retries), 16'(exp_retries));
    endtask

    task automatic start_tx(input logic [15:0] w);
        d_in  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered in HDR; leaves the bench in the first WAIT cycle.
    task automatic expect_frame(input string tag, input logic [15:0] w);
        chk({tag, ".hdr"}, {7'd0, cs, d_out}, {8'h00, 8'hCA});
        chk({tag, ".busy"}, 16'(busy), 16'h1);
        tick();
        chk({tag, ".hi"}, {7'd0, cs, d_out}, {8'h00, w[15:8]});
        tick();
        chk({tag, ".lo"}, {7'd0, cs, d_out}, {8'h00, w[7:0]});
        tick();
        chk({tag, ".wait"}, {7'd0, cs, d_out}, {8'h01, 8'h00});
        chk({tag, ".nodone"}, {14'd0, done, fail}, 16'h0);
    endtask

    task automatic ack_done(input string tag, input logic [1:0] exp_retries);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, ".done"}, {14'd0, done, fail}, 16'h2);
        chk_idle(tag, exp_retries);
        tick();
        chk({tag, ".pulse"}, {14'd0, done, fail}, 16'h0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk_idle("reset", 2'd0);
        chk("reset.flags", {14'd0, done, fail}, 16'h0);
        rst = 1'b0;
        tick();

        // Nominal send, ack in the second WAIT cycle
        start_tx(16'hFF01);
        expect_frame("nom", 16'hFF01);
        tick();
        chk("nom.wait2", {14'd0, done, busy}, 16'h1);
        ack_done("nom", 2'd0);

        // Retry: err on the first attempt, ack on the second
        start_tx(16'h1234);
        expect_frame("rty1", 16'h1234);
        err = 1'b1;
        tick();
        err = 1'b0;
        chk("rty.gap1", {13'd0, cs, busy, done}, 16'h6);
        chk("rty.cnt", 16'(retries), 16'h1);
        tick();
        chk("rty.gap2", {13'd0, cs, busy, done}, 16'h6);
        tick();
        expect_frame("rty2", 16'h1234);
        ack_done("rty", 2'd1);
        tick();
        chk("rty.hold", 16'(retries), 16'h1);

        // Exhaustion: no response at all
        start_tx(16'h5A5A);
        for (int a = 0; a < 3; a++) begin
            expect_frame("exh", 16'h5A5A);
            for (int c = 2; c <= 8; c++) begin
                tick();
                chk("exh.wait", {13'd0, cs, busy, fail}, 16'h6);
            end
            tick();
            if (a < 2) begin
                chk("exh.gap", {13'd0, cs, busy, fail}, 16'h6);
                chk("exh.retries", 16'(retries), 16'(a + 1));
                tick();
                tick();
            end else begin
                chk("exh.fail", {14'd0, done, fail}, 16'h1);
                chk_idle("exh", 2'd2);
                tick();
                chk("exh.pulse", {14'd0, done, fail}, 16'h0);
            end
        end

        // Ignored inputs: ack during HDR, start and new d_in during HI
        d_in  = 16'h3C5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b1;
        chk("ign.hdr", {7'd0, cs, d_out}, {8'h00, 8'hCA});
        chk("ign.retries", 16'(retries), 16'h0);
        tick();
        ack   = 1'b0;
        start = 1'b1;
        d_in  = 16'hAAAA;
        chk("ign.hi", {7'd0, cs, d_out}, {8'h00, 8'h3C});
        tick();
        start = 1'b0;
        chk("ign.lo", {7'd0, cs, d_out}, {8'h00, 8'h5A});
        tick();
        chk("ign.wait", {13'd0, cs, busy, done}, 16'h6);
        ack_done("ign", 2'd0);
        chk("ign.noq", 16'(busy), 16'h0);

        // Simultaneous ack and err counts as a failure
        start_tx(16'hBEEF);
        expect_frame("sim1", 16'hBEEF);
        ack = 1'b1;
        err = 1'b1;
        tick();
        ack = 1'b0;
        err = 1'b0;
        chk("sim.flags", {13'd0, busy, done, fail}, 16'h4);
        chk("sim.retries", 16'(retries), 16'h1);
        tick();
        tick();
        expect_frame("sim2", 16'hBEEF);
        ack_done("sim", 2'd1);

        // Reset during LO aborts silently, then a fresh send works
        start_tx(16'hC3C3);
        tick();
        tick();
        chk("rst.lo", {7'd0, cs, d_out}, {8'h00, 8'hC3});
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("rst", 2'd0);
        chk("rst.flags", {14'd0, done, fail}, 16'h0);
        rst = 1'b0;
        tick();
        chk("rst.after", {13'd0, busy, done, fail}, 16'h0);
        start_tx(16'h1357);
        expect_frame("post", 16'h1357);
        ack_done("post", 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
